// File: rtl/mem_access_sequencer.sv
// mem_access_sequencer
//   Arbitrates between the instruction-fetch port and the load/store port.
//   Each transaction loads the MAR, then drives the memory read or write
//   strobe until mem_ready or a timeout, and then returns read data and an
//   error flag to the requester that owns it with a one-cycle done pulse.
//
// Ports
//   clk, reset                 clock and synchronous active-high reset
//   if_req, if_addr, if_done   fetch request, address and completion pulse
//   ls_req, ls_we, ls_addr,
//   ls_wdata, ls_done          data request (we=1 store), address, store
//                              data and completion pulse
//   rsp_rdata, rsp_err         response data and timeout flag, valid with
//                              the done pulse and held until the next one
//   busy                       high whenever a transaction is in progress
//   mar_load, mar_addr         MAR load strobe and address
//   mem_rd, mem_wr, mem_wdata  memory strobes and store data
//   mem_rdata, mem_ready       memory read data and completion handshake
module mem_access_sequencer #(
  parameter int DATA_WIDTH     = 32,
  parameter int TIMEOUT_CYCLES = 16
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  if_req,
  input  logic [DATA_WIDTH-1:0] if_addr,
  output logic                  if_done,
  input  logic                  ls_req,
  input  logic                  ls_we,
  input  logic [DATA_WIDTH-1:0] ls_addr,
  input  logic [DATA_WIDTH-1:0] ls_wdata,
  output logic                  ls_done,
  output logic [DATA_WIDTH-1:0] rsp_rdata,
  output logic                  rsp_err,
  output logic                  busy,
  output logic                  mar_load,
  output logic [DATA_WIDTH-1:0] mar_addr,
  output logic                  mem_rd,
  output logic                  mem_wr,
  output logic [DATA_WIDTH-1:0] mem_wdata,
  input  logic [DATA_WIDTH-1:0] mem_rdata,
  input  logic                  mem_ready
);

  localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

  typedef enum logic [1:0] {IDLE, LOAD_MAR, ACCESS, RESP} state_t;

  state_t                  state;
  logic                    last_ls;   // 1 = data port won the previous grant
  logic                    own_ls;    // owner of the current transaction
  logic                    we_q;
  logic [DATA_WIDTH-1:0]   wdata_q;
  logic [CNT_W-1:0]        cnt;
  logic                    grant_ls;

  // A lone requester always wins; on a tie the port that lost last time wins.
  assign grant_ls = ls_req && (!if_req || !last_ls);

  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= IDLE;
      last_ls   <= 1'b1;
      own_ls    <= 1'b0;
      we_q      <= 1'b0;
      wdata_q   <= '0;
      cnt       <= '0;
      if_done   <= 1'b0;
      ls_done   <= 1'b0;
      rsp_rdata <= '0;
      rsp_err   <= 1'b0;
      busy      <= 1'b0;
      mar_load  <= 1'b0;
      mar_addr  <= '0;
      mem_rd    <= 1'b0;
      mem_wr    <= 1'b0;
      mem_wdata <= '0;
    end else begin
      if_done  <= 1'b0;
      ls_done  <= 1'b0;
      mar_load <= 1'b0;
      case (state)
        IDLE: begin
          if (if_req || ls_req) begin
            state    <= LOAD_MAR;
            busy     <= 1'b1;
            own_ls   <= grant_ls;
            last_ls  <= grant_ls;
            we_q     <= grant_ls && ls_we;
            wdata_q  <= ls_wdata;
            // mar_addr doubles as the latched address; it holds until the
            // next grant.
            mar_load <= 1'b1;
            mar_addr <= grant_ls ? ls_addr : if_addr;
          end
        end
        LOAD_MAR: begin
          state  <= ACCESS;
          cnt    <= '0;
          mem_rd <= !we_q;
          mem_wr <= we_q;
          if (we_q) mem_wdata <= wdata_q;
        end
        ACCESS: begin
          if (mem_ready) begin
            state   <= RESP;
            mem_rd  <= 1'b0;
            mem_wr  <= 1'b0;
            rsp_err <= 1'b0;
            // Stores leave the previous read data in place.
            if (!we_q) rsp_rdata <= mem_rdata;
            if (own_ls) ls_done <= 1'b1;
            else        if_done <= 1'b1;
          end else if (cnt == CNT_LAST) begin
            state     <= RESP;
            mem_rd    <= 1'b0;
            mem_wr    <= 1'b0;
            rsp_err   <= 1'b1;
            rsp_rdata <= '0;
            if (own_ls) ls_done <= 1'b1;
            else        if_done <= 1'b1;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        RESP: begin
          state <= IDLE;
          busy  <= 1'b0;
        end
        default: begin
          state <= IDLE;
          busy  <= 1'b0;
        end
      endcase
    end
  end

endmodule
